// File: rtl/reg_write_demux_if.sv
// Register-file bus: one write port, two combinational read ports and write statistics.
// The register file is the slave; whatever drives write-back and read indices is the master.
interface reg_write_demux_if #(
    parameter int WIDTH = 32
);
    logic             we;
    logic [4:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [4:0]       raddr1;
    logic [4:0]       raddr2;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [15:0]      wr_count;
    logic [4:0]       last_waddr;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, wr_count, last_waddr
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, wr_count, last_waddr
    );
endinterface

// File: rtl/reg_write_demux.sv
// 31-entry register file (r0 hard-wired to zero) fed by a 1-to-32 one-hot write demux,
// with two combinational read ports and optional same-cycle write-to-read bypass.
module reg_write_demux #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_write_demux_if.slave   bus
);
    logic [WIDTH-1:0] regs_q [1:31];
    logic [31:0]      wsel;
    logic             commit;
    logic [15:0]      wr_count_q, wr_count_d;
    logic [4:0]       last_waddr_q, last_waddr_d;
    logic [WIDTH-1:0] rdata1_d, rdata2_d;

    // Bit 0 is cleared after decode so a write to r0 selects nothing and never commits.
    always_comb begin
        wsel             = '0;
        wsel[bus.waddr]  = bus.we;
        wsel[0]          = 1'b0;
    end

    assign commit = |wsel;

    always_comb begin
        wr_count_d   = wr_count_q;
        last_waddr_d = last_waddr_q;
        if (commit) begin
            wr_count_d   = wr_count_q + 16'd1;
            last_waddr_d = bus.waddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q   <= '0;
            last_waddr_q <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wsel[i]) begin
                    regs_q[i] <= bus.wdata;
                end
            end
            wr_count_q   <= wr_count_d;
            last_waddr_q <= last_waddr_d;
        end
    end

    // Reads are gated by rst_n so a write presented during reset cannot leak through the bypass.
    always_comb begin
        rdata1_d = '0;
        if (rst_n && (bus.raddr1 != 5'd0)) begin
            rdata1_d = regs_q[bus.raddr1];
            if (BYPASS && commit && (bus.waddr == bus.raddr1)) begin
                rdata1_d = bus.wdata;
            end
        end
    end

    always_comb begin
        rdata2_d = '0;
        if (rst_n && (bus.raddr2 != 5'd0)) begin
            rdata2_d = regs_q[bus.raddr2];
            if (BYPASS && commit && (bus.waddr == bus.raddr2)) begin
                rdata2_d = bus.wdata;
            end
        end
    end

    assign bus.rdata1     = rdata1_d;
    assign bus.rdata2     = rdata2_d;
    assign bus.wr_count   = wr_count_q;
    assign bus.last_waddr = last_waddr_q;
endmodule

// File: tb/tb_reg_write_demux.sv
// Scoreboard bench for reg_write_demux: a BYPASS=1 and a BYPASS=0 instance share stimulus,
// expected read data and statistics come from an array model of the architectural registers.
module tb_reg_write_demux;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_write_demux_if #(.WIDTH(32)) ifb ();
    reg_write_demux_if #(.WIDTH(32)) ifn ();

    reg_write_demux #(.WIDTH(32), .BYPASS(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    reg_write_demux #(.WIDTH(32), .BYPASS(1'b0)) dut_n (.clk(clk), .rst_n(rst_n), .bus(ifn));

    typedef struct {
        logic [31:0] b1;
        logic [31:0] b2;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [15:0] cnt;
        logic [4:0]  last;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [32];
    logic [15:0] m_cnt;
    logic [4:0]  m_last;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        m_cnt  = 16'h0;
        m_last = 5'd0;
    endtask

    // Reference read: r0 is always zero, a committed same-cycle write wins only with bypass.
    function automatic logic [31:0] model_read(input logic [4:0] ra, input bit byp,
                                               input logic we, input logic [4:0] wa,
                                               input logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
        if (byp && we && (wa == ra)) return wd;
        return mem[ra];
    endfunction

    task automatic set_bus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] r1, input logic [4:0] r2);
        ifb.we = we; ifb.waddr = wa; ifb.wdata = wd; ifb.raddr1 = r1; ifb.raddr2 = r2;
        ifn.we = we; ifn.waddr = wa; ifn.wdata = wd; ifn.raddr1 = r1; ifn.raddr2 = r2;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(posedge clk);
        #1;
        set_bus(we, wa, wd, r1, r2);
        e.b1   = model_read(r1, 1'b1, we, wa, wd);
        e.b2   = model_read(r2, 1'b1, we, wa, wd);
        e.n1   = model_read(r1, 1'b0, we, wa, wd);
        e.n2   = model_read(r2, 1'b0, we, wa, wd);
        e.cnt  = m_cnt;
        e.last = m_last;
        sb.push_back(e);
        if (we && (wa != 5'd0)) begin
            mem[wa] = wd;
            m_cnt   = m_cnt + 16'd1;
            m_last  = wa;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rdata1_byp",     ifb.rdata1, e.b1);
                chk("rdata2_byp",     ifb.rdata2, e.b2);
                chk("rdata1_nobyp",   ifn.rdata1, e.n1);
                chk("rdata2_nobyp",   ifn.rdata2, e.n2);
                chk("wr_count_byp",   {16'h0, ifb.wr_count},   {16'h0, e.cnt});
                chk("wr_count_nobyp", {16'h0, ifn.wr_count},   {16'h0, e.cnt});
                chk("last_waddr_byp", {27'h0, ifb.last_waddr}, {27'h0, e.last});
                chk("last_waddr_nby", {27'h0, ifn.last_waddr}, {27'h0, e.last});
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_zero_now(input string tag);
        chk({tag, "_rdata1_byp"},   ifb.rdata1, 32'h0);
        chk({tag, "_rdata2_byp"},   ifb.rdata2, 32'h0);
        chk({tag, "_rdata1_nobyp"}, ifn.rdata1, 32'h0);
        chk({tag, "_wr_count"},     {16'h0, ifb.wr_count},   32'h0);
        chk({tag, "_last_waddr"},   {27'h0, ifb.last_waddr}, 32'h0);
    endtask

    initial begin : stimulus
        logic [4:0] wa;
        int         drain;
        rst_n = 1'b0;
        set_bus(1'b1, 5'd5, 32'hCAFE_F00D, 5'd5, 5'd31);
        model_reset();
        #12;
        check_zero_now("rst_held");
        set_bus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        drive(1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0, 5'd0);
        drive(1'b1, 5'd31, 32'h1234_5678, 5'd0, 5'd0);
        drive(1'b0, 5'd0,  32'h0,         5'd5, 5'd31);

        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'h0,         5'd0, 5'd31);

        drive(1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0);
        drive(1'b1, 5'd7, 32'h0000_00AA, 5'd7, 5'd7);
        drive(1'b0, 5'd0, 32'h0,         5'd7, 5'd7);

        repeat (3000) begin
            wa = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
        end

        // Reset dropped mid-cycle with a write to r3 pending.
        drive(1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd3);
        @(posedge clk);
        #1;
        set_bus(1'b1, 5'd3, 32'h0000_0077, 5'd3, 5'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_now("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        set_bus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);

        for (int k = 0; k < 65536; k++) begin
            drive(1'b1, 5'((k % 31) + 1), $urandom, 5'((k % 31) + 1), 5'($urandom_range(0, 31)));
        end
        for (int i = 0; i < 32; i++) drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        drain = 0;
        while (sb.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'h0);
        #20;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
